rocket_launch_manager: RTL

//  Launch-side counterpart of the per-rocket motion controllers: owns NUM_ROCKETS rocket slots,

---
 rtl/rocket_pkg.sv | 18 +
 rtl/rocket_slot_fsm.sv | 60 ++++++
 rtl/rocket_launch_manager.sv | 134 +++++++++++++
 3 files changed

// File: rtl/rocket_pkg.sv
// Shared types and defaults for the rocket launch manager.
// Slot states, coordinate width and default launch parameters.
package rocket_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    FLIGHT = 2'd2
  } slot_state_t;

  localparam int COORD_W          = 11;
  localparam int DEF_NUM_ROCKETS  = 4;
  localparam int DEF_ROCKET_SPEED = -256;
  localparam int DEF_COOLDOWN     = 8;
  localparam int DEF_X_OFFSET     = 14;
  localparam int DEF_Y_OFFSET     = -10;

endpackage

// File: rtl/rocket_slot_fsm.sv
// Per-slot lifecycle: IDLE -> LAUNCH -> FLIGHT -> IDLE.
// Border is ignored in LAUNCH because the controller position is stale then.
module rocket_slot_fsm
  import rocket_pkg::*;
(
  input  logic clk,
  input  logic resetN,
  input  logic i_select,
  input  logic i_border,
  input  logic i_hit,
  output logic o_active,
  output logic o_idle,
  output logic o_next_active
);

  slot_state_t r_state;
  slot_state_t w_next;

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: launch on select, retire on border (flight only) or hit
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (i_select) begin
          w_next = LAUNCH;
        end
      end
      LAUNCH: begin
        if (i_hit) begin
          w_next = IDLE;
        end else begin
          w_next = FLIGHT;
        end
      end
      FLIGHT: begin
        if (i_border || i_hit) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Outputs decoded from current and next state
  always_comb begin
    o_active      = (r_state != IDLE);
    o_idle        = (r_state == IDLE);
    o_next_active = (w_next != IDLE);
  end

endmodule

// File: rtl/rocket_launch_manager.sv
// Rocket launch manager: fire latch, slot priority pick, cooldown, launch regs.
// Define AUTO_FIRE_EN to let a held fireReq request a launch every frame.
module rocket_launch_manager
  import rocket_pkg::*;
#(
  parameter int NUM_ROCKETS     = DEF_NUM_ROCKETS,
  parameter int ROCKET_SPEED    = DEF_ROCKET_SPEED,
  parameter int COOLDOWN_FRAMES = DEF_COOLDOWN,
  parameter int ROCKET_X_OFFSET = DEF_X_OFFSET,
  parameter int ROCKET_Y_OFFSET = DEF_Y_OFFSET
)(
  input  logic                               clk,
  input  logic                               resetN,
  input  logic                               startOfFrame,
  input  logic                               fireReq,
  input  logic signed [COORD_W-1:0]          playerTopLeftX,
  input  logic signed [COORD_W-1:0]          playerTopLeftY,
  input  logic [NUM_ROCKETS-1:0]             reachedBorder,
  input  logic [NUM_ROCKETS-1:0]             rocketHit,
  output logic [NUM_ROCKETS-1:0]             isActive,
  output logic signed [COORD_W-1:0]          initialSpeed,
  output logic signed [COORD_W-1:0]          initialX,
  output logic signed [COORD_W-1:0]          initialY,
  output logic                               launched,
  output logic [$clog2(NUM_ROCKETS+1)-1:0]   activeCount
);

  localparam int CNT_W = $clog2(NUM_ROCKETS + 1);
  localparam int CD_W  = $clog2(COOLDOWN_FRAMES + 2);

  logic                   r_fire_d;
  logic                   r_fire_latch;
  logic [CD_W-1:0]        r_cooldown;
  logic                   w_edge;
  logic                   w_fire;
  logic                   w_launch;
  logic [NUM_ROCKETS-1:0] w_idle;
  logic [NUM_ROCKETS-1:0] w_next_act;
  logic [NUM_ROCKETS-1:0] w_sel;
  logic [NUM_ROCKETS-1:0] w_select;
  logic [CNT_W-1:0]       w_cnt;

  // Rising edge of the fire button
  assign w_edge = fireReq & ~r_fire_d;

`ifdef AUTO_FIRE_EN
  assign w_fire = r_fire_latch | w_edge | fireReq;
`else
  assign w_fire = r_fire_latch | w_edge;
`endif

  assign w_launch = startOfFrame & w_fire
                  & (r_cooldown == '0) & (|w_idle);

  assign w_select = w_launch ? w_sel : '0;

  // Fire edge latch, held until the next frame boundary
  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_fire_d     <= 1'b0;
      r_fire_latch <= 1'b0;
    end else begin
      r_fire_d <= fireReq;
      if (startOfFrame) begin
        r_fire_latch <= 1'b0;
      end else if (w_edge) begin
        r_fire_latch <= 1'b1;
      end
    end
  end

  // Lowest-index idle slot wins
  always_comb begin
    w_sel = '0;
    for (int i = NUM_ROCKETS - 1; i >= 0; i--) begin
      if (w_idle[i]) begin
        w_sel = '0;
        w_sel[i] = 1'b1;
      end
    end
  end

  // Count slots that will be non-idle after this edge
  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < NUM_ROCKETS; i++) begin
      w_cnt = w_cnt + CNT_W'(w_next_act[i]);
    end
  end

  // Cooldown: reload on launch, otherwise count down per frame
  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_cooldown <= '0;
    end else if (w_launch) begin
      r_cooldown <= CD_W'(COOLDOWN_FRAMES);
    end else if (startOfFrame && (r_cooldown != '0)) begin
      r_cooldown <= r_cooldown - 1'b1;
    end
  end

  // Launch parameters, held until the next launch
  always_ff @(posedge clk) begin
    if (!resetN) begin
      initialX     <= '0;
      initialY     <= '0;
      initialSpeed <= '0;
      launched     <= 1'b0;
      activeCount  <= '0;
    end else begin
      launched    <= w_launch;
      activeCount <= w_cnt;
      if (w_launch) begin
        initialX     <= playerTopLeftX + COORD_W'(ROCKET_X_OFFSET);
        initialY     <= playerTopLeftY + COORD_W'(ROCKET_Y_OFFSET);
        initialSpeed <= COORD_W'(ROCKET_SPEED);
      end
    end
  end

  for (genvar g = 0; g < NUM_ROCKETS; g++) begin : g_slot
    rocket_slot_fsm u_slot (
      .clk           (clk),
      .resetN        (resetN),
      .i_select      (w_select[g]),
      .i_border      (reachedBorder[g]),
      .i_hit         (rocketHit[g]),
      .o_active      (isActive[g]),
      .o_idle        (w_idle[g]),
      .o_next_active (w_next_act[g])
    );
  end

endmodule
